// File: rtl/xlr8_fb_pkg.sv
// Shared types, register bit positions and hall-code decode for the FET-bridge feedback XB.
package xlr8_fb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2
  } fb_state_t;

  // CTRL register bits
  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_IRQ_EN  = 1;
  localparam int unsigned CTRL_CLR_ERR = 2;

  // STAT register bits; SECTOR occupies [2:0]
  localparam int unsigned STAT_DIR  = 3;
  localparam int unsigned STAT_ERR  = 4;
  localparam int unsigned STAT_OVF  = 5;
  localparam int unsigned STAT_EVT  = 6;
  localparam int unsigned STAT_LOCK = 7;

  // Returned for the two codes a healthy 120-degree sensor set never produces
  localparam logic [2:0] SECTOR_INVALID = 3'd7;

  // Gray-style 6-step hall code {fb3,fb2,fb1} to sector number
  function automatic logic [2:0] hall_to_sector(input logic [2:0] code);
    logic [2:0] s;
    case (code)
      3'b001:  s = 3'd0;
      3'b011:  s = 3'd1;
      3'b010:  s = 3'd2;
      3'b110:  s = 3'd3;
      3'b100:  s = 3'd4;
      3'b101:  s = 3'd5;
      default: s = SECTOR_INVALID;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] sector_inc(input logic [2:0] s);
    return (s == 3'd5) ? 3'd0 : s + 3'd1;
  endfunction

  function automatic logic [2:0] sector_dec(input logic [2:0] s);
    return (s == 3'd0) ? 3'd5 : s - 3'd1;
  endfunction

endpackage

// File: rtl/xlr8_fb_debounce.sv
// Two-flop synchroniser plus stability filter for the 3-bit feedback bus.
// The filtered code changes DEBOUNCE clken cycles after the synced code settles,
// and update_o pulses for one clken cycle whenever the filtered code changes value.
module xlr8_fb_debounce
  import xlr8_fb_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clken,
  input  logic [2:0] fb_raw_i,
  output logic [2:0] code_o,
  output logic       update_o
);

  localparam logic [3:0] CntLast = 4'(DEBOUNCE - 1);

  logic [2:0] sync1_q, sync2_q;
  logic [2:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] code_q, code_d;
  logic       upd_q, upd_d;

  // Candidate tracking and acceptance once the candidate has been stable long enough
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    code_d = code_q;
    upd_d  = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = 4'd0;
      // With a one-cycle filter the change itself already meets the stability count
      if ((CntLast == 4'd0) && (sync2_q != code_q)) begin
        code_d = sync2_q;
        upd_d  = 1'b1;
      end
    end else if (cnt_q < CntLast) begin
      cnt_d = cnt_q + 4'd1;
      if ((cnt_d == CntLast) && (cand_q != code_q)) begin
        code_d = cand_q;
        upd_d  = 1'b1;
      end
    end
  end

  // Synchroniser and filter state; a reset discards any partially debounced code
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
      cand_q  <= 3'b000;
      cnt_q   <= 4'd0;
      code_q  <= 3'b000;
      upd_q   <= 1'b0;
    end else if (clken) begin
      sync1_q <= fb_raw_i;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      upd_q   <= upd_d;
    end
  end

  assign code_o   = code_q;
  assign update_o = upd_q;

endmodule

// File: rtl/xlr8_fb_decode.sv
// FET-bridge feedback receiver: filters the three sensor lines, tracks the 6-step
// sector and rotation direction, times sector-to-sector intervals and exposes the
// results as AVR data-memory registers with a level interrupt.
module xlr8_fb_decode
  import xlr8_fb_pkg::*;
#(
  parameter logic [7:0]  FB_CTRL_ADDR = 8'h00,
  parameter logic [7:0]  FB_STAT_ADDR = 8'h00,
  parameter logic [7:0]  FB_PERL_ADDR = 8'h00,
  parameter logic [7:0]  FB_PERH_ADDR = 8'h00,
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned PER_WIDTH    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clken,
  input  logic [7:0] dbus_in,
  output logic [7:0] dbus_out,
  output logic       io_out_en,
  input  logic [7:0] ramadr,
  input  logic       ramre,
  input  logic       ramwe,
  input  logic       dm_sel,
  input  logic       feedback_1,
  input  logic       feedback_2,
  input  logic       feedback_3,
  output logic       fb_irq
);

  localparam logic [PER_WIDTH-1:0] CntMax = '1;

  // Filtered code from the debouncer
  logic [2:0] f_code;
  logic       f_update;
  logic [2:0] f_sector;

  // Register state
  fb_state_t            state_q, state_d;
  logic                 en_q, en_d;
  logic                 irq_en_q, irq_en_d;
  logic [2:0]           sector_q, sector_d;
  logic                 dir_q, dir_d;
  logic                 err_q, err_d;
  logic                 ovf_q, ovf_d;
  logic                 evt_q, evt_d;
  logic [PER_WIDTH-1:0] period_q, period_d;
  logic [PER_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]           shadow_q, shadow_d;

  // Bus decode
  logic       sel_ctrl, sel_stat, sel_perl, sel_perh;
  logic       ctrl_we, stat_re, perl_re, clr_err;
  logic       evt_set, err_set;
  logic [7:0] ctrl_rd, stat_rd;
  logic [PER_WIDTH-1:0] cnt_inc;
  logic       unused_dbus;

  xlr8_fb_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .clken    (clken),
    .fb_raw_i ({feedback_3, feedback_2, feedback_1}),
    .code_o   (f_code),
    .update_o (f_update)
  );

  assign f_sector = hall_to_sector(f_code);
  assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

  assign sel_ctrl = dm_sel && (ramadr == FB_CTRL_ADDR);
  assign sel_stat = dm_sel && (ramadr == FB_STAT_ADDR);
  assign sel_perl = dm_sel && (ramadr == FB_PERL_ADDR);
  assign sel_perh = dm_sel && (ramadr == FB_PERH_ADDR);

  assign ctrl_we = clken && sel_ctrl && ramwe;
  assign stat_re = clken && sel_stat && ramre;
  assign perl_re = clken && sel_perl && ramre;
  assign clr_err = ctrl_we && dbus_in[CTRL_CLR_ERR];

  // Bits above CLR_ERR are reserved and ignored on write
  assign unused_dbus = ^dbus_in[7:3];

  // Register read data and bus drive
  always_comb begin
    ctrl_rd = 8'h00;
    ctrl_rd[CTRL_EN]     = en_q;
    ctrl_rd[CTRL_IRQ_EN] = irq_en_q;

    stat_rd = 8'h00;
    stat_rd[2:0]       = sector_q;
    stat_rd[STAT_DIR]  = dir_q;
    stat_rd[STAT_ERR]  = err_q;
    stat_rd[STAT_OVF]  = ovf_q;
    stat_rd[STAT_EVT]  = evt_q;
    stat_rd[STAT_LOCK] = (state_q == TRACK);

    dbus_out = ({8{sel_ctrl}} & ctrl_rd)
             | ({8{sel_stat}} & stat_rd)
             | ({8{sel_perl}} & period_q[7:0])
             | ({8{sel_perh}} & shadow_q);
    io_out_en = (sel_ctrl || sel_stat || sel_perl || sel_perh) && ramre;
  end

  // Control register writes and the PERL-triggered high-byte snapshot
  always_comb begin
    en_d     = en_q;
    irq_en_d = irq_en_q;
    shadow_d = shadow_q;
    if (ctrl_we) begin
      en_d     = dbus_in[CTRL_EN];
      irq_en_d = dbus_in[CTRL_IRQ_EN];
    end
    // Non-blocking capture means a same-cycle period latch still yields the old high byte
    if (perl_re) begin
      shadow_d = period_q[15:8];
    end
  end

  // Sector tracking FSM, interval counter and event detection
  always_comb begin
    state_d  = state_q;
    sector_d = sector_q;
    dir_d    = dir_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    evt_set  = 1'b0;
    err_set  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en_q) begin
          state_d = ACQUIRE;
        end
      end
      ACQUIRE: begin
        cnt_d = '0;
        if (!en_q) begin
          state_d = IDLE;
        end else if (f_sector != SECTOR_INVALID) begin
          sector_d = f_sector;
          state_d  = TRACK;
        end
      end
      TRACK: begin
        if (!en_q) begin
          state_d = IDLE;
        end else if (f_update && (f_sector == SECTOR_INVALID)) begin
          err_set = 1'b1;
          cnt_d   = cnt_inc;
        end else if (f_update && (f_sector != sector_q)) begin
          if (f_sector == sector_inc(sector_q)) begin
            dir_d = 1'b1;
          end else if (f_sector == sector_dec(sector_q)) begin
            dir_d = 1'b0;
          end else begin
            err_set = 1'b1;
          end
          sector_d = f_sector;
          period_d = cnt_q;
          cnt_d    = {{(PER_WIDTH-1){1'b0}}, 1'b1};
          evt_set  = 1'b1;
          ovf_d    = (cnt_q == CntMax);
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    // Setting a sticky flag takes priority over clearing it in the same cycle
    evt_d = evt_set | (evt_q & ~stat_re);
    err_d = err_set | (err_q & ~clr_err);
  end

  // State registers, all gated by the clock enable
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      sector_q <= 3'd0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      evt_q    <= 1'b0;
      period_q <= '0;
      cnt_q    <= '0;
      shadow_q <= 8'h00;
    end else if (clken) begin
      state_q  <= state_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      sector_q <= sector_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      evt_q    <= evt_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  assign fb_irq = irq_en_q & evt_q;

endmodule

// File: tb/tb_xlr8_fb_decode.sv
// Directed bench for the feedback decoder: register map, sector/direction tracking,
// debounce boundary, period saturation and the atomic period read.
module tb_xlr8_fb_decode;

  localparam logic [7:0] A_CTRL = 8'h50;
  localparam logic [7:0] A_STAT = 8'h51;
  localparam logic [7:0] A_PERL = 8'h52;
  localparam logic [7:0] A_PERH = 8'h53;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clken = 1'b1;
  logic [7:0] dbus_in = 8'h00;
  logic [7:0] dbus_out;
  logic       io_out_en;
  logic [7:0] ramadr = 8'h00;
  logic       ramre = 1'b0;
  logic       ramwe = 1'b0;
  logic       dm_sel = 1'b0;
  logic       feedback_1 = 1'b0;
  logic       feedback_2 = 1'b0;
  logic       feedback_3 = 1'b0;
  logic       fb_irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  xlr8_fb_decode #(
    .FB_CTRL_ADDR (A_CTRL),
    .FB_STAT_ADDR (A_STAT),
    .FB_PERL_ADDR (A_PERL),
    .FB_PERH_ADDR (A_PERH),
    .DEBOUNCE     (4),
    .PER_WIDTH    (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clken      (clken),
    .dbus_in    (dbus_in),
    .dbus_out   (dbus_out),
    .io_out_en  (io_out_en),
    .ramadr     (ramadr),
    .ramre      (ramre),
    .ramwe      (ramwe),
    .dm_sel     (dm_sel),
    .feedback_1 (feedback_1),
    .feedback_2 (feedback_2),
    .feedback_3 (feedback_3),
    .fb_irq     (fb_irq)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_fb(input logic [2:0] c);
    {feedback_3, feedback_2, feedback_1} = c;
  endtask

  // One-cycle read: data and io_out_en are checked before the clocking edge
  task automatic rd(input logic [7:0] addr, input logic [7:0] exp, input string tag);
    dm_sel = 1'b1;
    ramadr = addr;
    ramre  = 1'b1;
    #1;
    chk(tag, dbus_out, exp);
    chk({tag, "_oe"}, {7'd0, io_out_en}, 8'h01);
    @(posedge clk);
    #1;
    ramre  = 1'b0;
    dm_sel = 1'b0;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    dm_sel  = 1'b1;
    ramadr  = addr;
    dbus_in = data;
    ramwe   = 1'b1;
    @(posedge clk);
    #1;
    ramwe   = 1'b0;
    dm_sel  = 1'b0;
    dbus_in = 8'h00;
  endtask

  initial begin
    // Reset state
    tick(3);
    rst = 1'b0;
    tick(1);
    rd(A_CTRL, 8'h00, "rst_ctrl");
    rd(A_STAT, 8'h00, "rst_stat");
    rd(A_PERL, 8'h00, "rst_perl");
    rd(A_PERH, 8'h00, "rst_perh");
    chk("rst_irq", {7'd0, fb_irq}, 8'h00);

    // io_out_en only for a read strobe to a mapped address
    dm_sel = 1'b1;
    ramadr = A_STAT;
    ramre  = 1'b0;
    #1;
    chk("oe_no_re", {7'd0, io_out_en}, 8'h00);
    ramadr = 8'h60;
    ramre  = 1'b1;
    #1;
    chk("oe_unmapped", {7'd0, io_out_en}, 8'h00);
    ramre  = 1'b0;
    dm_sel = 1'b0;

    // Enable, acquire on sector 0, then a 100-cycle interval 1 -> 2
    wr(A_CTRL, 8'h03);
    set_fb(3'b001);
    tick(10);
    rd(A_STAT, 8'h80, "acq_stat");
    rd(A_CTRL, 8'h03, "ctrl_rb");
    set_fb(3'b011);
    tick(100);
    set_fb(3'b010);
    tick(10);
    chk("irq_set", {7'd0, fb_irq}, 8'h01);
    rd(A_STAT, 8'hCA, "fwd_stat");
    chk("irq_clr", {7'd0, fb_irq}, 8'h00);
    rd(A_STAT, 8'h8A, "evt_clr");
    rd(A_PERL, 8'h64, "per100_l");
    rd(A_PERH, 8'h00, "per100_h");

    // Forward to 5, then reverse 5 -> 4 -> 3
    set_fb(3'b110); tick(10);
    set_fb(3'b100); tick(10);
    set_fb(3'b101); tick(10);
    set_fb(3'b100); tick(10);
    rd(A_STAT, 8'hC4, "rev_4");
    set_fb(3'b110); tick(10);
    rd(A_STAT, 8'hC3, "rev_3");

    // Walk back to 0 then jump 0 -> 3
    set_fb(3'b010); tick(10);
    set_fb(3'b011); tick(10);
    set_fb(3'b001); tick(10);
    set_fb(3'b110); tick(10);
    chk("jump_irq", {7'd0, fb_irq}, 8'h01);
    rd(A_STAT, 8'hD3, "jump_err");
    wr(A_CTRL, 8'h07);
    rd(A_STAT, 8'h83, "clr_err");
    rd(A_CTRL, 8'h03, "clr_err_ctrl");

    // 3-cycle glitch is rejected, 4-cycle excursion is accepted both ways
    set_fb(3'b100); tick(3);
    set_fb(3'b110); tick(10);
    rd(A_STAT, 8'h83, "glitch3");
    set_fb(3'b100); tick(4);
    set_fb(3'b110); tick(10);
    rd(A_STAT, 8'hC3, "hold4");
    rd(A_PERL, 8'h04, "hold4_per");

    // Saturating interval
    set_fb(3'b100); tick(70000);
    set_fb(3'b101); tick(10);
    rd(A_STAT, 8'hED, "ovf_stat");
    rd(A_PERL, 8'hFF, "ovf_perl");
    rd(A_PERH, 8'hFF, "ovf_perh");
    set_fb(3'b100); tick(10);
    rd(A_STAT, 8'hC4, "ovf_clr");

    // Atomic read: PERH reflects the period at PERL time, not a later latch
    set_fb(3'b110); tick(291);
    set_fb(3'b100); tick(10);
    rd(A_STAT, 8'hCC, "p291_stat");
    rd(A_PERL, 8'h23, "p291_l");
    set_fb(3'b101); tick(10);
    rd(A_PERH, 8'h01, "shadow_old");
    rd(A_PERL, 8'h0C, "p12_l");
    rd(A_PERH, 8'h00, "p12_h");
    rd(A_STAT, 8'hCD, "p12_stat");

    // Illegal code in TRACK keeps the sector and flags an error
    set_fb(3'b111); tick(10);
    rd(A_STAT, 8'h9D, "illegal");

    // Disable: back to IDLE with sector and flags retained
    wr(A_CTRL, 8'h00);
    tick(2);
    rd(A_STAT, 8'h1D, "idle_keep");
    chk("idle_irq", {7'd0, fb_irq}, 8'h00);

    // Mid-operation reset
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    rd(A_STAT, 8'h00, "rst2_stat");
    rd(A_PERH, 8'h00, "rst2_perh");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
